// File: rtl/run_ctrl_pkg.sv
// run_ctrl_pkg: shared state encoding and default constants for the run controller
package run_ctrl_pkg;

    typedef enum logic [1:0] {IDLE, ARM, RUN, HALT} run_state_t;

    localparam int          ADDR_W_DEF    = 5;
    localparam logic [31:0] HALT_WORD_DEF = 32'hFFFF_FFFF;

endpackage

// File: rtl/run_cycle_counter.sv
// run_cycle_counter: saturating executed-cycle counter with limit compare
module run_cycle_counter #(
    parameter int CYC_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic [CYC_W-1:0] limit,
    output logic [CYC_W-1:0] count,
    output logic             hit
);

    // hit flags the enabled cycle that brings the count up to a non-zero limit
    always_comb begin
        hit = en && (limit != '0) && (count == limit - CYC_W'(1));
    end

    // clear wins over enable; the count sticks at all-ones instead of wrapping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count <= '0;
        else if (clr)
            count <= '0;
        else if (en && count != '1)
            count <= count + CYC_W'(1);
    end

endmodule

// File: rtl/run_ctrl.sv
// run_ctrl: loads the instruction memory, then releases and gates the core until halt or cycle limit
module run_ctrl
    import run_ctrl_pkg::*;
#(
    parameter int                 ADDR_W    = ADDR_W_DEF,
    parameter int                 INSTR_W   = 32,
    parameter int                 CYC_W     = 16,
    parameter logic [INSTR_W-1:0] HALT_WORD = INSTR_W'(HALT_WORD_DEF)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load_valid,
    input  logic [INSTR_W-1:0] load_data,
    input  logic               load_last,
    output logic               load_ready,
    input  logic               start,
    input  logic               step_mode,
    input  logic               step,
    input  logic [CYC_W-1:0]   max_cycles,
    input  logic [INSTR_W-1:0] instr,
    output logic               imem_we,
    output logic [ADDR_W-1:0]  imem_waddr,
    output logic [INSTR_W-1:0] imem_wdata,
    output logic               cpu_rst_n,
    output logic               cpu_en,
    output logic               busy,
    output logic               done,
    output logic               timeout,
    output logic [CYC_W-1:0]   cycle_count
);

    run_state_t        state, state_d;
    logic [ADDR_W-1:0] wptr;
    logic              full;
    logic              load_ok;
    logic              accept;
    logic              halt_fetch;
    logic              hit;

    run_cycle_counter #(.CYC_W(CYC_W)) u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (state == ARM),
        .en    (cpu_en),
        .limit (max_cycles),
        .count (cycle_count),
        .hit   (hit)
    );

    // output decode and next state; a load accepted alongside start always wins
    always_comb begin
        load_ok    = (state == IDLE) || (state == HALT);
        load_ready = load_ok && !full;
        accept     = load_valid && load_ready;
        halt_fetch = instr == HALT_WORD;
        cpu_en     = (state == RUN) && !halt_fetch && (!step_mode || step);
        imem_we    = accept;
        imem_waddr = wptr;
        imem_wdata = load_data;
        busy       = (state == ARM) || (state == RUN);
        done       = state == HALT;
        state_d    = state;
        case (state)
            IDLE:    state_d = (start && !accept) ? ARM : IDLE;
            ARM:     state_d = RUN;
            RUN:     state_d = (halt_fetch || hit) ? HALT : RUN;
            HALT:    state_d = accept ? IDLE : (start ? ARM : HALT);
            default: state_d = IDLE;
        endcase
    end

    // state register, registered core reset and sticky limit flag for the last run
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cpu_rst_n <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            state     <= state_d;
            cpu_rst_n <= state_d != IDLE;
            if (state == ARM)
                timeout <= 1'b0;
            else if (state == RUN && hit)
                timeout <= 1'b1;
        end
    end

    // write pointer; wrapping past the top without a last word marks the memory full
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            full <= 1'b0;
        end else if (accept) begin
            wptr <= load_last ? '0 : wptr + ADDR_W'(1);
            full <= !load_last && (wptr == '1);
        end else if (load_ok && full && load_valid && load_last) begin
            wptr <= '0;
            full <= 1'b0;
        end
    end

endmodule

// File: tb/tb_run_ctrl.sv
// tb_run_ctrl: randomized program runs against a program-level model of the run controller
module tb_run_ctrl;

    localparam logic [31:0] HW = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load_valid, load_last, load_ready;
    logic [31:0] load_data;
    logic        start, step_mode, step;
    logic [15:0] max_cycles;
    logic [31:0] instr;
    logic        imem_we;
    logic [4:0]  imem_waddr;
    logic [31:0] imem_wdata;
    logic        cpu_rst_n, cpu_en, busy, done, timeout;
    logic [15:0] cycle_count;

    logic [31:0] mem [32] = '{default: '0};
    logic [4:0]  pc;
    logic [31:0] model [32];
    int          model_pc;
    int          n_checks = 0;
    int          n_err = 0;

    run_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_valid  (load_valid),
        .load_data   (load_data),
        .load_last   (load_last),
        .load_ready  (load_ready),
        .start       (start),
        .step_mode   (step_mode),
        .step        (step),
        .max_cycles  (max_cycles),
        .instr       (instr),
        .imem_we     (imem_we),
        .imem_waddr  (imem_waddr),
        .imem_wdata  (imem_wdata),
        .cpu_rst_n   (cpu_rst_n),
        .cpu_en      (cpu_en),
        .busy        (busy),
        .done        (done),
        .timeout     (timeout),
        .cycle_count (cycle_count)
    );

    always #5 clk = ~clk;

    // instruction memory and a minimal core: PC advances on every enabled cycle
    always @(posedge clk) if (imem_we) mem[imem_waddr] <= imem_wdata;
    always @(posedge clk or negedge cpu_rst_n)
        if (!cpu_rst_n) pc <= '0;
        else if (cpu_en) pc <= pc + 5'd1;
    assign instr = mem[pc];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] nh();
        return $urandom & 32'h7FFF_FFFF;
    endfunction

    task automatic load_prog(input logic [31:0] w[$], input bit with_start, input bit use_last);
        foreach (w[i]) begin
            load_valid = 1'b1;
            load_data  = w[i];
            load_last  = use_last && (i == w.size() - 1);
            start      = with_start && (i == 0);
            @(negedge clk);
            check("ld_ready", load_ready, 1);
            check("ld_we", imem_we, 1);
            check("ld_addr", imem_waddr, i);
            check("ld_data", imem_wdata, w[i]);
            model[i] = w[i];
            @(posedge clk); #1;
        end
        load_valid = 1'b0;
        load_last  = 1'b0;
        start      = 1'b0;
        model_pc   = 0;
        @(negedge clk);
        check("ld_idle", {busy, done}, 0);
        @(posedge clk); #1;
    endtask

    task automatic do_run(input bit sm, input int m);
        int  h = -1;
        int  exp_n, n_en = 0, bad = 0;
        bit  exp_to, fin = 0;
        for (int d = 0; d < 32; d++)
            if (h < 0 && model[(model_pc + d) % 32] == HW) h = d;
        if (m != 0 && (h < 0 || m <= h)) begin exp_n = m; exp_to = 1; end
        else begin exp_n = h; exp_to = 0; end
        model_pc   = (model_pc + exp_n) % 32;
        step_mode  = sm;
        max_cycles = 16'(m);
        start      = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check("arm_state", {busy, done, cpu_en, cpu_rst_n}, 4'b1001);
        for (int k = 0; k < 2000; k++) begin
            @(posedge clk); #1;
            step = sm && (k % 3 == 0);
            @(negedge clk);
            if (done) begin fin = 1; break; end
            if (k == 0 && !sm) check("first_en", cpu_en, exp_n > 0);
            if (cpu_en) n_en++;
            if (cpu_en && sm && !step) bad++;
        end
        step = 1'b0;
        check("run_done", fin, 1);
        check("run_en_cycles", n_en, exp_n);
        check("run_count", cycle_count, exp_n);
        check("run_timeout", timeout, exp_to);
        if (sm) check("step_gating", bad, 0);
        @(posedge clk); #1;
    endtask

    initial begin
        logic [31:0] q[$];
        int          m;
        bit          any;
        foreach (model[i]) model[i] = '0;
        model_pc   = 0;
        rst_n      = 1'b0;
        load_valid = 1'b0; load_last = 1'b0; load_data = '0;
        start = 1'b0; step_mode = 1'b0; step = 1'b0; max_cycles = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_outs", {load_ready, imem_we, cpu_rst_n, cpu_en, busy, done, timeout}, 7'b1000000);
        check("rst_count", cycle_count, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // load four words ending in the halt word, then a free run of three instructions
        q = {nh(), nh(), nh(), HW};
        load_prog(q, 0, 1);
        do_run(0, 0);

        // looping program with a limit of ten
        q = {nh(), nh(), nh(), nh(), nh()};
        load_prog(q, 0, 1);
        do_run(0, 10);

        // reset while running at cycle_count 5
        max_cycles = '0; step_mode = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (cycle_count == 16'd5) break;
        end
        check("mid_count", cycle_count, 5);
        rst_n = 1'b0;
        #1;
        check("mid_async", {cpu_rst_n, cpu_en}, 0);
        check("mid_outs", {load_ready, imem_we, busy, done, timeout}, 5'b10000);
        check("mid_cnt_rst", cycle_count, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_pc = 0;

        // start together with a load in IDLE: the word is written and start is dropped
        start = 1'b1; load_valid = 1'b1; load_last = 1'b1; load_data = nh();
        @(negedge clk);
        check("sim_we", imem_we, 1);
        check("sim_addr", imem_waddr, 0);
        model[0] = load_data;
        @(posedge clk); #1;
        start = 1'b0; load_valid = 1'b0; load_last = 1'b0;
        @(negedge clk);
        check("sim_idle", {busy, done, load_ready}, 3'b001);
        @(posedge clk); #1;

        // single step, then halt on the limit cycle and limit just before the halt
        q = {nh(), nh(), nh(), HW};
        load_prog(q, 0, 1);
        do_run(1, 0);
        load_prog(q, 1, 1);
        do_run(0, 4);
        load_prog(q, 1, 1);
        do_run(0, 3);

        // randomized programs, limits, step mode and occasional re-runs without reload
        for (int it = 0; it < 10; it++) begin
            if (it == 0 || $urandom_range(0, 3) != 0) begin
                int L = $urandom_range(1, 12);
                bit hh = 1'($urandom_range(0, 1));
                q = {};
                for (int i = 0; i < L; i++) q.push_back((hh && i == L - 1) ? HW : nh());
                load_prog(q, (it == 0) ? 1'b1 : 1'($urandom_range(0, 1)), 1);
            end
            any = 0;
            foreach (model[i]) if (model[i] == HW) any = 1;
            m = $urandom_range(0, 20);
            if (!any && m == 0) m = $urandom_range(1, 40);
            do_run(1'($urandom_range(0, 1)), m);
        end

        // fill all 32 words without a last word: loads stall until reset
        q = {};
        for (int i = 0; i < 32; i++) q.push_back(nh());
        load_prog(q, 0, 0);
        load_valid = 1'b1; load_data = nh();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("full_ready", load_ready, 0);
            check("full_we", imem_we, 0);
            @(posedge clk); #1;
        end
        rst_n = 1'b0; load_valid = 1'b0;
        #1;
        check("full_rst_ready", load_ready, 1);
        @(posedge clk); #1;
        rst_n = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
